// File: rtl/bus_mux_arbiter_if.sv
// Shared bus bundle for bus_mux_arbiter: per-channel requests/data in, one
// registered word out with valid/ready.
interface bus_mux_arbiter_if #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 16,
  parameter int SEL_W    = 4
);
  logic                      mode;
  logic [SEL_W-1:0]          sel;
  logic [CHANNELS-1:0]       req;
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       grant;
  logic                      out_valid;
  logic                      out_ready;
  logic [WIDTH-1:0]          out_data;
  logic [SEL_W-1:0]          out_chan;

  modport master (
    output mode, sel, req, in_data, out_ready,
    input  grant, out_valid, out_data, out_chan
  );

  modport slave (
    input  mode, sel, req, in_data, out_ready,
    output grant, out_valid, out_data, out_chan
  );
endinterface

// File: rtl/bus_mux_arbiter.sv
// Registered N:1 bus mux with direct-select or round-robin request/grant front end.
// One cycle grant-to-data latency; grant is withheld while a held word is not taken.
module bus_mux_arbiter #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 16,
  parameter int SEL_W    = 4
) (
  input  logic            clk,
  input  logic            rst,
  bus_mux_arbiter_if.slave bus
);

  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic [SEL_W-1:0] out_chan_q;
  logic [SEL_W-1:0] last;

  logic             has_cand;
  logic [SEL_W-1:0] cand;
  logic [WIDTH-1:0] cand_data;
  logic             load;

  always_comb begin
    has_cand  = 1'b0;
    cand      = '0;
    cand_data = '0;
    if (!bus.mode) begin
      // Out-of-range sel never matches any channel, so it yields no candidate.
      for (int i = 0; i < CHANNELS; i++) begin
        if (bus.sel == SEL_W'(i) && bus.req[i]) begin
          has_cand  = 1'b1;
          cand      = SEL_W'(i);
          cand_data = bus.in_data[i*WIDTH +: WIDTH];
        end
      end
    end else begin
      // Scan farthest-first so the channel nearest after last overwrites the rest.
      for (int k = CHANNELS; k >= 1; k--) begin
        if (bus.req[(int'(last) + k) % CHANNELS]) begin
          has_cand  = 1'b1;
          cand      = SEL_W'((int'(last) + k) % CHANNELS);
          cand_data = bus.in_data[((int'(last) + k) % CHANNELS)*WIDTH +: WIDTH];
        end
      end
    end
  end

  assign load = has_cand && (!out_valid_q || bus.out_ready);

  always_comb begin
    bus.grant = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      bus.grant[i] = load && !rst && (cand == SEL_W'(i));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      last        <= SEL_W'(CHANNELS - 1);
    end else if (load) begin
      out_valid_q <= 1'b1;
      out_data_q  <= cand_data;
      out_chan_q  <= cand;
      if (bus.mode) begin
        last <= cand;
      end
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_chan  = out_chan_q;

endmodule

// File: tb/tb_bus_mux_arbiter.sv
// Directed bench for bus_mux_arbiter: a 16-channel instance plus a 12-channel one for out-of-range select.
module tb_bus_mux_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  bus_mux_arbiter_if #(.WIDTH(16), .CHANNELS(16), .SEL_W(4)) bus ();
  bus_mux_arbiter_if #(.WIDTH(16), .CHANNELS(12), .SEL_W(4)) bus12 ();

  bus_mux_arbiter #(.WIDTH(16), .CHANNELS(16), .SEL_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  bus_mux_arbiter #(.WIDTH(16), .CHANNELS(12), .SEL_W(4)) dut12 (
    .clk (clk),
    .rst (rst),
    .bus (bus12)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] word_of(input int i);
    return 16'(32'hC000 + i * 257);
  endfunction

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.mode = 1'b0;
    bus.sel = 4'd5;
    bus.req = 16'h0020;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 16; i++) bus.in_data[i*16 +: 16] = word_of(i);
    bus.in_data[5*16 +: 16] = 16'hA5A5;
    bus.in_data[3*16 +: 16] = 16'h1234;
    bus12.mode = 1'b0;
    bus12.sel = 4'd13;
    bus12.req = 12'hFFF;
    bus12.out_ready = 1'b1;
    for (int i = 0; i < 12; i++) bus12.in_data[i*16 +: 16] = word_of(i);

    // Reset: grant forced low even though req[sel] is up
    #1;
    chk("grant_in_reset", 32'(bus.grant), 32'h0);
    tick();
    tick();
    bus.req = 16'h0;
    rst = 1'b0;
    #1;
    chk("rst_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_data", 32'(bus.out_data), 32'h0);
    chk("rst_chan", 32'(bus.out_chan), 32'h0);
    chk("rst_grant", 32'(bus.grant), 32'h0);
    tick();
    chk("idle_valid", 32'(bus.out_valid), 32'h0);

    // Direct select of channel 5
    bus.req = 16'h0020;
    #1;
    chk("dir5_grant", 32'(bus.grant), 32'h0020);
    tick();
    chk("dir5_valid", 32'(bus.out_valid), 32'h1);
    chk("dir5_data", 32'(bus.out_data), 32'hA5A5);
    chk("dir5_chan", 32'(bus.out_chan), 32'h5);
    bus.req = 16'h0;
    tick();
    chk("dir5_drain", 32'(bus.out_valid), 32'h0);
    chk("dir5_hold_data", 32'(bus.out_data), 32'hA5A5);

    // Round-robin, all requesting: 0..15,0,1 with no bubble
    bus.mode = 1'b1;
    bus.req = 16'hFFFF;
    for (int k = 0; k < 18; k++) begin
      #1;
      chk($sformatf("rr_grant_%0d", k), 32'(bus.grant), 32'h1 << (k % 16));
      tick();
      chk($sformatf("rr_chan_%0d", k), 32'(bus.out_chan), 32'(k % 16));
      chk($sformatf("rr_valid_%0d", k), 32'(bus.out_valid), 32'h1);
    end
    bus.req = 16'h0;
    tick();
    chk("rr_drain", 32'(bus.out_valid), 32'h0);

    // Backpressure: hold 0x1234 from channel 3 for 4 cycles
    bus.mode = 1'b0;
    bus.sel = 4'd3;
    bus.req = 16'h0008;
    #1;
    chk("bp_grant3", 32'(bus.grant), 32'h0008);
    tick();
    chk("bp_data3", 32'(bus.out_data), 32'h1234);
    chk("bp_chan3", 32'(bus.out_chan), 32'h3);
    bus.out_ready = 1'b0;
    bus.sel = 4'd6;
    bus.req = 16'h0040;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("bp_stall_grant_%0d", k), 32'(bus.grant), 32'h0);
      tick();
      chk($sformatf("bp_stall_data_%0d", k), 32'(bus.out_data), 32'h1234);
      chk($sformatf("bp_stall_valid_%0d", k), 32'(bus.out_valid), 32'h1);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_resume_grant", 32'(bus.grant), 32'h0040);
    tick();
    chk("bp_resume_data", 32'(bus.out_data), 32'(word_of(6)));
    chk("bp_resume_chan", 32'(bus.out_chan), 32'h6);
    bus.req = 16'h0;
    tick();
    chk("bp_drain", 32'(bus.out_valid), 32'h0);

    // Sparse round-robin around last=9, with a direct load in between
    bus.mode = 1'b1;
    bus.req = 16'h0200;
    #1;
    chk("sp_set_last9", 32'(bus.grant), 32'h0200);
    tick();
    bus.req = 16'h0204;
    #1;
    chk("sp_grant_2a", 32'(bus.grant), 32'h0004);
    tick();
    chk("sp_chan_2a", 32'(bus.out_chan), 32'h2);
    bus.mode = 1'b0;
    bus.sel = 4'd9;
    #1;
    chk("sp_direct9_grant", 32'(bus.grant), 32'h0200);
    tick();
    chk("sp_direct9_chan", 32'(bus.out_chan), 32'h9);
    bus.mode = 1'b1;
    #1;
    chk("sp_grant_9", 32'(bus.grant), 32'h0200);
    tick();
    chk("sp_chan_9", 32'(bus.out_chan), 32'h9);
    #1;
    chk("sp_grant_2b", 32'(bus.grant), 32'h0004);
    tick();
    chk("sp_chan_2b", 32'(bus.out_chan), 32'h2);

    // Direct mode with req[sel]=0 while others request
    bus.mode = 1'b0;
    bus.sel = 4'd4;
    bus.req = 16'h0003;
    #1;
    chk("dm_nocand_grant", 32'(bus.grant), 32'h0);
    tick();
    chk("dm_nocand_valid", 32'(bus.out_valid), 32'h0);

    // 12-channel instance: sel=13 is out of range and never granted
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("c12_sel13_grant_%0d", k), 32'(bus12.grant), 32'h0);
      chk($sformatf("c12_sel13_valid_%0d", k), 32'(bus12.out_valid), 32'h0);
      tick();
    end
    bus12.sel = 4'd11;
    #1;
    chk("c12_sel11_grant", 32'(bus12.grant), 32'h800);
    tick();
    chk("c12_sel11_data", 32'(bus12.out_data), 32'(word_of(11)));
    bus12.mode = 1'b1;
    bus12.req = 12'h801;
    bus12.out_ready = 1'b0;

    // Async reset mid-cycle with a held word
    bus.mode = 1'b1;
    bus.req = 16'h0004;
    bus.out_ready = 1'b0;
    tick();
    chk("ar_held_valid", 32'(bus.out_valid), 32'h1);
    #3;
    rst = 1'b1;
    #1;
    chk("ar_valid_clr", 32'(bus.out_valid), 32'h0);
    chk("ar_data_clr", 32'(bus.out_data), 32'h0);
    chk("ar_grant_clr", 32'(bus.grant), 32'h0);
    chk("ar_c12_valid_clr", 32'(bus12.out_valid), 32'h0);
    rst = 1'b0;
    bus.req = 16'h8001;
    bus.out_ready = 1'b1;
    #1;
    chk("ar_first_grant", 32'(bus.grant), 32'h0001);
    chk("ar_c12_first_grant", 32'(bus12.grant), 32'h001);
    tick();
    chk("ar_first_chan", 32'(bus.out_chan), 32'h0);
    chk("ar_second_grant", 32'(bus.grant), 32'h8000);
    tick();
    chk("ar_second_chan", 32'(bus.out_chan), 32'hF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
